// File: rtl/net_msg_inqueue_if.sv
// Receive-word and messenger request signals of the inbound message queue.
// slave is the queue side; master is the network/messenger side.
interface net_msg_inqueue_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          RXSTB;
  logic          RXSOP;
  logic [31:0]   RXDAT;
  logic          RXRDY;
  logic          NETREQ;
  logic [121:0]  NETPARAM;
  logic          NETMSGRD;
  logic [AW:0]   COUNT;
  logic          OVF;
  logic          PROTERR;

  modport slave (
    input  RXSTB, RXSOP, RXDAT, NETMSGRD,
    output RXRDY, NETREQ, NETPARAM, COUNT, OVF, PROTERR
  );

  modport master (
    output RXSTB, RXSOP, RXDAT, NETMSGRD,
    input  RXRDY, NETREQ, NETPARAM, COUNT, OVF, PROTERR
  );
endinterface

// File: rtl/net_msg_inqueue.sv
// Inbound network message queue: assembles 4-word messages into 122-bit
// entries, buffers them, and presents the head on NETREQ/NETPARAM.
module net_msg_inqueue #(
  parameter int DEPTH = 8
) (
  input  logic                CLK,
  input  logic                RESETn,
  net_msg_inqueue_if.slave    io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, GOT0, GOT1, GOT2} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_w0, r_w1, r_w2;
  logic          w_cap0, w_cap1, w_cap2;
  logic          w_commit;
  logic          w_proterr;

  logic [121:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wrptr, r_rdptr;
  logic [AW:0]   r_count;
  logic          r_ovf, r_proterr;
  logic          w_full, w_empty, w_push, w_pop;
  logic [121:0]  w_entry;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // SOP always restarts a message; a missing SOP or a SOP mid-message is a framing error.
  always_comb begin
    w_state_next = r_state;
    w_cap0       = 1'b0;
    w_cap1       = 1'b0;
    w_cap2       = 1'b0;
    w_commit     = 1'b0;
    w_proterr    = 1'b0;
    if (io_bus.RXSTB) begin
      if (io_bus.RXSOP) begin
        w_cap0       = 1'b1;
        w_proterr    = (r_state != IDLE);
        w_state_next = GOT0;
      end else begin
        case (r_state)
          IDLE: w_proterr = 1'b1;
          GOT0: begin w_cap1 = 1'b1; w_state_next = GOT1; end
          GOT1: begin w_cap2 = 1'b1; w_state_next = GOT2; end
          GOT2: begin w_commit = 1'b1; w_state_next = IDLE; end
          default: w_state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_cap0) r_w0 <= io_bus.RXDAT;
    if (w_cap1) r_w1 <= io_bus.RXDAT;
    if (w_cap2) r_w2 <= io_bus.RXDAT;
  end

  assign w_entry = {io_bus.RXDAT[25:0], r_w2, r_w1, r_w0};
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = io_bus.NETMSGRD & ~w_empty;
  // A full queue still accepts the commit when the head is popped on the same edge.
  assign w_push  = w_commit & (~w_full | io_bus.NETMSGRD);

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wrptr] <= w_entry;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wrptr   <= '0;
      r_rdptr   <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_proterr <= 1'b0;
    end else begin
      if (w_push) r_wrptr <= r_wrptr + 1'b1;
      if (w_pop)  r_rdptr <= r_rdptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_ovf     <= w_commit & ~w_push;
      r_proterr <= w_proterr;
    end
  end

  // Head read is asynchronous so an entry is visible the cycle after its write.
  assign io_bus.NETPARAM = w_empty ? '0 : r_mem[r_rdptr];
  assign io_bus.NETREQ   = ~w_empty;
  assign io_bus.RXRDY    = ~w_full;
  assign io_bus.COUNT    = r_count;
  assign io_bus.OVF      = r_ovf;
  assign io_bus.PROTERR  = r_proterr;
endmodule

// File: tb/tb_net_msg_inqueue.sv
// Directed and randomized checks of net_msg_inqueue against a queue-based
// reference model of message assembly, FIFO order, overflow and framing errors.
module tb_net_msg_inqueue;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  net_msg_inqueue_if #(.DEPTH(DEPTH)) bus ();

  net_msg_inqueue #(.DEPTH(DEPTH)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .io_bus (bus)
  );

  // reference model
  logic [121:0] q[$];
  int           nw;
  logic [31:0]  sw[3];
  logic         exp_ovf, exp_perr;

  int tests = 0;
  int fails = 0;
  int rd_pct;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [121:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    chk({ctx, ".NETREQ"},   128'(bus.NETREQ),   128'(q.size() > 0));
    chk({ctx, ".COUNT"},    128'(bus.COUNT),    128'(q.size()));
    chk({ctx, ".NETPARAM"}, 128'(bus.NETPARAM), 128'(head));
    chk({ctx, ".RXRDY"},    128'(bus.RXRDY),    128'(q.size() < DEPTH));
    chk({ctx, ".OVF"},      128'(bus.OVF),      128'(exp_ovf));
    chk({ctx, ".PROTERR"},  128'(bus.PROTERR),  128'(exp_perr));
  endtask

  task automatic model_clear();
    q.delete();
    nw = 0;
    exp_ovf = 1'b0;
    exp_perr = 1'b0;
  endtask

  // One clock: drive inputs, advance model, check outputs 1 time unit after the edge.
  task automatic cycle(input string ctx, input logic stb, input logic sop,
                       input logic [31:0] dat, input logic rd);
    logic         commit;
    logic [121:0] entry;
    bus.RXSTB = stb;
    bus.RXSOP = sop;
    bus.RXDAT = dat;
    bus.NETMSGRD = rd;
    exp_ovf = 1'b0;
    exp_perr = 1'b0;
    commit = 1'b0;
    entry = '0;
    if (stb) begin
      if (sop) begin
        if (nw != 0) exp_perr = 1'b1;
        sw[0] = dat;
        nw = 1;
      end else if (nw == 0) begin
        exp_perr = 1'b1;
      end else if (nw < 3) begin
        sw[nw] = dat;
        nw++;
      end else begin
        entry = {dat[25:0], sw[2], sw[1], sw[0]};
        commit = 1'b1;
        nw = 0;
      end
    end
    if (rd && q.size() > 0) begin
      $display("[TB] pop  %h", q[0]);
      void'(q.pop_front());
    end
    if (commit) begin
      if (q.size() < DEPTH) begin
        q.push_back(entry);
        $display("[TB] push %h", entry);
      end else begin
        exp_ovf = 1'b1;
        $display("[TB] drop %h (queue full)", entry);
      end
    end
    @(posedge CLK);
    #1;
    check_outputs(ctx);
  endtask

  task automatic send_msg(input string ctx, input logic [31:0] w0, w1, w2, w3,
                          input logic rd_on_w3);
    cycle(ctx, 1'b1, 1'b1, w0, 1'b0);
    cycle(ctx, 1'b1, 1'b0, w1, 1'b0);
    cycle(ctx, 1'b1, 1'b0, w2, 1'b0);
    cycle(ctx, 1'b1, 1'b0, w3, rd_on_w3);
  endtask

  task automatic idle(input string ctx, input int n, input logic rd);
    for (int i = 0; i < n; i++) cycle(ctx, 1'b0, 1'b0, 32'h0, rd);
  endtask

  task automatic pops(input string ctx, input int n);
    for (int i = 0; i < n; i++) cycle(ctx, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [121:0] tp_param;
    bus.RXSTB = 1'b0;
    bus.RXSOP = 1'b0;
    bus.RXDAT = '0;
    bus.NETMSGRD = 1'b0;
    model_clear();
    tp_param = {2'b10, 24'hABCDEF, 16'h1234, 16'h0005, 32'hCAFEBABE, 32'h00000011};

    // reset state
    @(posedge CLK);
    #1;
    check_outputs("reset");
    @(negedge CLK);
    RESETn = 1'b1;

    // single message, then pop
    send_msg("msg1", 32'h00000011, 32'hCAFEBABE, 32'h12340005, 32'h02ABCDEF, 1'b0);
    chk("msg1.const_param", 128'(bus.NETPARAM), 128'(tp_param));
    chk("msg1.const_count", 128'(bus.COUNT), 128'd1);
    pops("msg1_pop", 1);

    // nine messages without pops: ninth overflows
    for (int m = 1; m <= 9; m++)
      send_msg("fill9", 32'h100 + m, 32'h200 + m, 32'h300 + m, 32'hFC000000 | (32'h400 + m), 1'b0);
    chk("fill9.const_count", 128'(bus.COUNT), 128'(DEPTH));
    pops("drain8", 8);
    idle("empty", 1, 1'b0);

    // full queue with pop coincident with W3 of message 9
    for (int m = 1; m <= 8; m++)
      send_msg("fill8", $urandom, $urandom, $urandom, $urandom, 1'b0);
    send_msg("full_pop", 32'hAAAA0009, 32'hBBBB0009, 32'hCCCC0009, 32'h01DDDD09, 1'b1);
    pops("drain_fp", 8);

    // SOP after W1 aborts the partial message
    cycle("abort", 1'b1, 1'b1, 32'hDEAD0000, 1'b0);
    cycle("abort", 1'b1, 1'b0, 32'hDEAD0001, 1'b0);
    send_msg("abort_new", 32'h0000A000, 32'h0000A001, 32'h0000A002, 32'h0300A003, 1'b0);
    chk("abort.const_count", 128'(bus.COUNT), 128'd1);
    // word without SOP while idle
    cycle("nosop", 1'b1, 1'b0, 32'h12345678, 1'b0);
    pops("abort_pop", 1);

    // pop on empty queue, then a normal message
    pops("empty_pop", 3);
    send_msg("after_empty", 32'h5, 32'h6, 32'h7, 32'h8, 1'b0);
    pops("after_empty_pop", 1);

    // asynchronous reset mid-message with three entries queued
    for (int m = 0; m < 3; m++)
      send_msg("pre_rst", $urandom, $urandom, $urandom, $urandom, 1'b0);
    cycle("pre_rst_w0", 1'b1, 1'b1, 32'h11, 1'b0);
    cycle("pre_rst_w1", 1'b1, 1'b0, 32'h22, 1'b0);
    cycle("pre_rst_w2", 1'b1, 1'b0, 32'h33, 1'b0);
    bus.RXSTB = 1'b0;
    bus.RXSOP = 1'b0;
    #2;
    RESETn = 1'b0;
    #1;
    model_clear();
    check_outputs("async_rst");
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    cycle("w3_only", 1'b1, 1'b0, 32'h02ABCDEF, 1'b0);

    // randomized traffic in a low-pop and a high-pop phase
    for (int i = 0; i < 1200; i++) begin
      logic stb, sop, rd;
      rd_pct = (i < 600) ? 10 : 45;
      stb = ($urandom_range(0, 99) < 80);
      sop = (nw == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      rd  = ($urandom_range(0, 99) < rd_pct);
      cycle("rand", stb, sop, $urandom, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
